// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
// Bus bundle for the scoreboarded register file.
//   Read side   : rd_en, addr1, addr2   -> out1, out2, busy1, busy2
//   Write side  : wr_en, addr_in, in    (writeback, clears pending bit)
//   Issue side  : set_en, set_addr      (decode marks a register pending)
// master = decode/writeback logic driving the file, slave = the register file.
// -----------------------------------------------------------------------------
interface regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              rd_en;
   logic [ADDR_W-1:0] addr1;
   logic [ADDR_W-1:0] addr2;
   logic [DATA_W-1:0] out1;
   logic [DATA_W-1:0] out2;
   logic              busy1;
   logic              busy2;
   logic              wr_en;
   logic [ADDR_W-1:0] addr_in;
   logic [DATA_W-1:0] in;
   logic              set_en;
   logic [ADDR_W-1:0] set_addr;

   modport master (
      output rd_en, addr1, addr2, wr_en, addr_in, in, set_en, set_addr,
      input  out1, out2, busy1, busy2
   );

   modport slave (
      input  rd_en, addr1, addr2, wr_en, addr_in, in, set_en, set_addr,
      output out1, out2, busy1, busy2
   );
endinterface

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// 2-read / 1-write register file with a pending-write (busy) bit per register.
// Ports:
//   clk : clock, all state changes on posedge
//   rst : asynchronous, active-low reset (clears registers, busy bits, outputs)
//   sb  : regfile_sb_if.slave bundle
//         reads  (rd_en, addr1/2 -> out1/2, busy1/2), latency 1, hold when rd_en=0
//         write  (wr_en, addr_in, in) stores data and clears busy
//         issue  (set_en, set_addr) marks a register busy; wins over a clear
// Addresses >= DEPTH are ignored for writes/sets and read back as 0 / not busy.
// With ZERO_REG=1 register 0 is hardwired to 0 and never busy.
// With BYPASS=1 a same-cycle write is forwarded to the read outputs.
// -----------------------------------------------------------------------------
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic          clk,
   input logic          rst,
   regfile_sb_if.slave  sb
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic [DATA_W-1:0] r_out1;
   logic [DATA_W-1:0] r_out2;
   logic              r_busy1;
   logic              r_busy2;

   logic              w_wr_ok;
   logic              w_set_ok;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [IDX_W-1:0]  w_set_idx;
   logic [DEPTH-1:0]  w_busy_nxt;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_bsy1;
   logic              w_bsy2;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (32'(a) < DEPTH);
   endfunction

   // Address that may hold state: inside the file and not the hardwired zero.
   function automatic logic is_live(input logic [ADDR_W-1:0] a);
      return in_range(a) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   function automatic logic [DATA_W-1:0] rd_value(
      input logic [ADDR_W-1:0] a,
      input logic              wr_en,
      input logic [ADDR_W-1:0] wr_addr,
      input logic [DATA_W-1:0] wr_data
   );
      if (!is_live(a)) begin
         return '0;
      end
      if ((BYPASS != 0) && wr_en && (wr_addr == a)) begin
         return wr_data;
      end
      return r_mem[IDX_W'(a)];
   endfunction

   // Busy lookup uses the post-edge vector so a same-cycle clear/set is seen.
   function automatic logic rd_busy(
      input logic [ADDR_W-1:0] a,
      input logic [DEPTH-1:0]  vec
   );
      if (!in_range(a)) begin
         return 1'b0;
      end
      return vec[IDX_W'(a)];
   endfunction

   assign w_wr_ok   = sb.wr_en  && is_live(sb.addr_in);
   assign w_set_ok  = sb.set_en && is_live(sb.set_addr);
   assign w_wr_idx  = IDX_W'(sb.addr_in);
   assign w_set_idx = IDX_W'(sb.set_addr);

   // Set is applied after clear: a newly issued producer keeps the register busy
   // even though the older producer's data lands this cycle.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wr_ok) begin
         w_busy_nxt[w_wr_idx] = 1'b0;
      end
      if (w_set_ok) begin
         w_busy_nxt[w_set_idx] = 1'b1;
      end
   end

   always_comb begin
      w_rd1  = rd_value(sb.addr1, sb.wr_en, sb.addr_in, sb.in);
      w_rd2  = rd_value(sb.addr2, sb.wr_en, sb.addr_in, sb.in);
      w_bsy1 = rd_busy(sb.addr1, w_busy_nxt);
      w_bsy2 = rd_busy(sb.addr2, w_busy_nxt);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_busy  <= '0;
         r_out1  <= '0;
         r_out2  <= '0;
         r_busy1 <= 1'b0;
         r_busy2 <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_mem[w_wr_idx] <= sb.in;
         end
         r_busy <= w_busy_nxt;
         if (sb.rd_en) begin
            r_out1  <= w_rd1;
            r_out2  <= w_rd2;
            r_busy1 <= w_bsy1;
            r_busy2 <= w_bsy2;
         end
      end
   end

   assign sb.out1  = r_out1;
   assign sb.out2  = r_out2;
   assign sb.busy1 = r_busy1;
   assign sb.busy2 = r_busy2;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Directed bench for regfile_sb. Three instances share one stimulus stream:
//   dut_a : DEPTH=32, ZERO_REG=1, BYPASS=1 (default configuration)
//   dut_b : DEPTH=32, ZERO_REG=0, BYPASS=0
//   dut_c : DEPTH=16, ZERO_REG=1, BYPASS=1
// -----------------------------------------------------------------------------
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        rd_en;
   logic [4:0]  addr1;
   logic [4:0]  addr2;
   logic        wr_en;
   logic [4:0]  addr_in;
   logic [31:0] in_data;
   logic        set_en;
   logic [4:0]  set_addr;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) if_a ();
   regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
   regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) if_c ();

   assign if_a.rd_en = rd_en;   assign if_b.rd_en = rd_en;   assign if_c.rd_en = rd_en;
   assign if_a.addr1 = addr1;   assign if_b.addr1 = addr1;   assign if_c.addr1 = addr1;
   assign if_a.addr2 = addr2;   assign if_b.addr2 = addr2;   assign if_c.addr2 = addr2;
   assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;   assign if_c.wr_en = wr_en;
   assign if_a.addr_in = addr_in;  assign if_b.addr_in = addr_in;  assign if_c.addr_in = addr_in;
   assign if_a.in = in_data;    assign if_b.in = in_data;    assign if_c.in = in_data;
   assign if_a.set_en = set_en; assign if_b.set_en = set_en; assign if_c.set_en = set_en;
   assign if_a.set_addr = set_addr; assign if_b.set_addr = set_addr; assign if_c.set_addr = set_addr;

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(1))
      dut_a (.clk(clk), .rst(rst), .sb(if_a.slave));
   regfile_sb #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(0), .BYPASS(0))
      dut_b (.clk(clk), .rst(rst), .sb(if_b.slave));
   regfile_sb #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .ZERO_REG(1), .BYPASS(1))
      dut_c (.clk(clk), .rst(rst), .sb(if_c.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd_en = 1'b0; addr1 = '0; addr2 = '0;
      wr_en = 1'b0; addr_in = '0; in_data = '0;
      set_en = 1'b0; set_addr = '0;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      idle();
      wr_en = 1'b1; addr_in = a; in_data = d;
      tick();
   endtask

   task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
      idle();
      rd_en = 1'b1; addr1 = a1; addr2 = a2;
      tick();
   endtask

   initial begin
      idle();

      // ---- reset: activity while rst=0 must be ignored
      wr_en = 1'b1; addr_in = 5'd5; in_data = 32'hDEADBEEF;
      rd_en = 1'b1; addr1 = 5'd5; addr2 = 5'd5;
      set_en = 1'b1; set_addr = 5'd5;
      tick(); tick(); tick();
      chk("rst_out1",  if_a.out1, 32'h0);
      chk("rst_out2",  if_a.out2, 32'h0);
      chk("rst_busy1", {31'b0, if_a.busy1}, 32'h0);
      chk("rst_busy2", {31'b0, if_a.busy2}, 32'h0);
      idle();
      rst = 1'b1;
      tick();
      do_read(5'd5, 5'd5);
      chk("post_rst_out1",  if_a.out1, 32'h0);
      chk("post_rst_busy1", {31'b0, if_a.busy1}, 32'h0);

      // ---- basic write then read on both ports
      do_write(5'd7, 32'h12345678);
      do_read(5'd7, 5'd7);
      chk("basic_out1_a", if_a.out1, 32'h12345678);
      chk("basic_out2_a", if_a.out2, 32'h12345678);
      chk("basic_out1_b", if_b.out1, 32'h12345678);
      chk("basic_out2_c", if_c.out2, 32'h12345678);

      // ---- zero register: write + set on reg 0
      idle();
      wr_en = 1'b1; addr_in = 5'd0; in_data = 32'hFFFFFFFF;
      set_en = 1'b1; set_addr = 5'd0;
      tick();
      do_read(5'd0, 5'd7);
      chk("zero_out1_a",  if_a.out1, 32'h0);
      chk("zero_busy1_a", {31'b0, if_a.busy1}, 32'h0);
      chk("zero_out1_b",  if_b.out1, 32'hFFFFFFFF);
      chk("zero_busy1_b", {31'b0, if_b.busy1}, 32'h1);

      // ---- bypass: write and read reg 9 in the same cycle
      idle();
      wr_en = 1'b1; addr_in = 5'd9; in_data = 32'hA5A5A5A5;
      rd_en = 1'b1; addr1 = 5'd9; addr2 = 5'd7;
      tick();
      chk("byp_out1_a", if_a.out1, 32'hA5A5A5A5);
      chk("byp_out1_b", if_b.out1, 32'h0);
      chk("byp_out2_a", if_a.out2, 32'h12345678);
      do_read(5'd9, 5'd9);
      chk("byp_stored_b", if_b.out1, 32'hA5A5A5A5);

      // ---- scoreboard on reg 4
      idle();
      set_en = 1'b1; set_addr = 5'd4;
      tick();
      do_read(5'd4, 5'd9);
      chk("sb_set_busy1", {31'b0, if_a.busy1}, 32'h1);
      chk("sb_other_busy2", {31'b0, if_a.busy2}, 32'h0);
      idle();
      wr_en = 1'b1; addr_in = 5'd4; in_data = 32'h55;
      rd_en = 1'b1; addr1 = 5'd4; addr2 = 5'd4;
      tick();
      chk("sb_clr_busy1_a", {31'b0, if_a.busy1}, 32'h0);
      chk("sb_clr_out1_a",  if_a.out1, 32'h55);
      chk("sb_clr_busy1_b", {31'b0, if_b.busy1}, 32'h0);
      chk("sb_clr_out1_b",  if_b.out1, 32'h0);
      idle();
      wr_en = 1'b1; addr_in = 5'd4; in_data = 32'h66;
      set_en = 1'b1; set_addr = 5'd4;
      rd_en = 1'b1; addr1 = 5'd4; addr2 = 5'd4;
      tick();
      chk("sb_both_busy1", {31'b0, if_a.busy1}, 32'h1);
      chk("sb_both_out1",  if_a.out1, 32'h66);
      do_read(5'd4, 5'd4);
      chk("sb_both_stored", if_a.out2, 32'h66);
      chk("sb_both_busy2",  {31'b0, if_a.busy2}, 32'h1);
      chk("sb_both_out1_b", if_b.out1, 32'h66);

      // ---- out of range on the 16-deep instance
      do_write(5'd4, 32'h77);
      idle();
      wr_en = 1'b1; addr_in = 5'd20; in_data = 32'hBAD0BAD0;
      set_en = 1'b1; set_addr = 5'd20;
      tick();
      do_read(5'd20, 5'd4);
      chk("oor_out1_c",  if_c.out1, 32'h0);
      chk("oor_busy1_c", {31'b0, if_c.busy1}, 32'h0);
      chk("oor_alias_out2_c",  if_c.out2, 32'h77);
      chk("oor_alias_busy2_c", {31'b0, if_c.busy2}, 32'h0);
      chk("inr_out1_a",  if_a.out1, 32'hBAD0BAD0);
      chk("inr_busy1_a", {31'b0, if_a.busy1}, 32'h1);
      do_read(5'd16, 5'd15);
      chk("oor16_out1_c", if_c.out1, 32'h0);
      chk("r15_out2_c",   if_c.out2, 32'h0);
      do_read(5'd7, 5'd9);
      chk("keep7_c", if_c.out1, 32'h12345678);
      chk("keep9_c", if_c.out2, 32'hA5A5A5A5);

      // ---- rd_en=0 holds outputs
      idle();
      addr1 = 5'd4; addr2 = 5'd0;
      wr_en = 1'b1; addr_in = 5'd7; in_data = 32'h0BADF00D;
      tick();
      tick();
      chk("hold_out1_c", if_c.out1, 32'h12345678);
      chk("hold_out2_c", if_c.out2, 32'hA5A5A5A5);
      do_read(5'd7, 5'd7);
      chk("after_hold_c", if_c.out1, 32'h0BADF00D);

      // ---- asynchronous reset in the middle of a write
      idle();
      wr_en = 1'b1; addr_in = 5'd9; in_data = 32'h11111111;
      set_en = 1'b1; set_addr = 5'd9;
      #2;
      rst = 1'b0;
      #1;
      chk("async_out1_a", if_a.out1, 32'h0);
      chk("async_busy_a", {31'b0, if_a.busy1}, 32'h0);
      tick();
      idle();
      rst = 1'b1;
      tick();
      do_read(5'd9, 5'd7);
      chk("async_r9_a",  if_a.out1, 32'h0);
      chk("async_b9_a",  {31'b0, if_a.busy1}, 32'h0);
      chk("async_r7_a",  if_a.out2, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
